// File: rtl/note_arbiter.sv
// rtl/note_arbiter.sv - two-requester note arbiter for the square-wave voice
// Optional feature macro: NOTE_ARB_PREEMPT_EN (requester 1 may preempt a requester-0 note).
module note_arbiter #(
  parameter int HP_W      = 7,
  parameter int LEN_W     = 5,
  parameter int GAP_TICKS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             req0_valid,
  input  logic [HP_W-1:0]  req0_hp,
  input  logic [LEN_W-1:0] req0_len,
  input  logic             req1_valid,
  input  logic [HP_W-1:0]  req1_hp,
  input  logic [LEN_W-1:0] req1_len,
  output logic             req0_ready,
  output logic             req1_ready,
  output logic [HP_W-1:0]  hp,
  output logic             active,
  output logic             grant,
  output logic             busy
);

  typedef enum logic [1:0] {S_IDLE, S_ON, S_GAP} state_t;

  state_t           state, state_nxt;
  logic [LEN_W-1:0] on_cnt, gap_cnt;
  logic             xfer0, xfer1, xfer;
  logic             preempt_ok;

`ifdef NOTE_ARB_PREEMPT_EN
  // Only a requester-0 note can be cut short; requester-1 notes always run out.
  assign preempt_ok = (state != S_IDLE) && !grant;
`else
  assign preempt_ok = 1'b0;
`endif

  assign xfer0 = req0_valid && req0_ready;
  assign xfer1 = req1_valid && req1_ready;
  assign xfer  = xfer0 || xfer1;

  // State register; active/busy are registered decodes of the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      active <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state  <= state_nxt;
      active <= (state_nxt == S_ON);
      busy   <= (state_nxt != S_IDLE);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (xfer) state_nxt = S_ON;
      S_ON: begin
        if (xfer) state_nxt = S_ON;
        else if (tick && on_cnt == LEN_W'(1))
          state_nxt = (GAP_TICKS > 0) ? S_GAP : S_IDLE;
      end
      S_GAP: begin
        if (xfer) state_nxt = S_ON;
        else if (tick && gap_cnt == LEN_W'(1)) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req1_ready = 1'b0;
    req0_ready = 1'b0;
    if (rst_n) begin
      req1_ready = req1_valid && ((state == S_IDLE) || preempt_ok);
      req0_ready = req0_valid && !req1_valid && (state == S_IDLE);
    end
  end

  // Note datapath; a transfer cycle loads counts and ignores that cycle's tick.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hp      <= '0;
      grant   <= 1'b0;
      on_cnt  <= '0;
      gap_cnt <= '0;
    end else if (xfer) begin
      hp      <= xfer1 ? req1_hp : req0_hp;
      grant   <= xfer1;
      gap_cnt <= '0;
      if (xfer1) on_cnt <= (req1_len == '0) ? LEN_W'(1) : req1_len;
      else       on_cnt <= (req0_len == '0) ? LEN_W'(1) : req0_len;
    end else if (tick) begin
      if (state == S_ON && on_cnt != '0) begin
        on_cnt <= on_cnt - LEN_W'(1);
        if (on_cnt == LEN_W'(1)) gap_cnt <= LEN_W'(GAP_TICKS);
      end else if (state == S_GAP && gap_cnt != '0) begin
        gap_cnt <= gap_cnt - LEN_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_note_arbiter.sv
// tb/tb_note_arbiter.sv - directed checks for note_arbiter (default and zero-gap instances)
module tb_note_arbiter;

  logic       clk = 1'b0;
  logic       rst_n, tick, v0, v1;
  logic [6:0] h0, h1;
  logic [4:0] l0, l1;
  logic       r0, r1, act, gnt, bsy;
  logic [6:0] hp;
  logic       z_r0, z_r1, z_act, z_gnt, z_bsy;
  logic [6:0] z_hp;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  note_arbiter dut (
    .clk(clk), .rst_n(rst_n), .tick(tick),
    .req0_valid(v0), .req0_hp(h0), .req0_len(l0),
    .req1_valid(v1), .req1_hp(h1), .req1_len(l1),
    .req0_ready(r0), .req1_ready(r1),
    .hp(hp), .active(act), .grant(gnt), .busy(bsy)
  );

  note_arbiter #(.GAP_TICKS(0)) dut_nogap (
    .clk(clk), .rst_n(rst_n), .tick(tick),
    .req0_valid(v0), .req0_hp(h0), .req0_len(l0),
    .req1_valid(v1), .req1_hp(h1), .req1_len(l1),
    .req0_ready(z_r0), .req1_ready(z_r1),
    .hp(z_hp), .active(z_act), .grant(z_gnt), .busy(z_bsy)
  );

  typedef struct {
    logic       rn, tk, v0;
    logic [6:0] h0;
    logic [4:0] l0;
    logic       er0;
    logic [6:0] ehp;
    logic       eact, egnt, ebsy;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rn, tk, vv0, input int hh0, ll0,
                     input logic er0, input int ehp, input logic eact, egnt, ebsy);
    vec_t v;
    v.rn = rn; v.tk = tk; v.v0 = vv0; v.h0 = 7'(hh0); v.l0 = 5'(ll0);
    v.er0 = er0; v.ehp = 7'(ehp); v.eact = eact; v.egnt = egnt; v.ebsy = ebsy;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Drive inputs just after a rising edge, then return at the falling edge for sampling.
  task automatic cyc(input logic rn, tk, vv0, vv1, input int hh0, ll0, hh1, ll1);
    @(posedge clk); #1;
    rst_n = rn; tick = tk; v0 = vv0; v1 = vv1;
    h0 = 7'(hh0); l0 = 5'(ll0); h1 = 7'(hh1); l1 = 5'(ll1);
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && bsy !== 1'b0; i++) cyc(1, 1, 0, 0, 0, 0, 0, 0);
    chk("drain_to_idle", bsy, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst_n = 0; tick = 0; v0 = 0; v1 = 0; h0 = 0; h1 = 0; l0 = 0; l1 = 0;
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);

    // rn tk v0 hp0 len0 | r0 hp act gnt busy
    add(0, 0, 1, 47, 3,   0,  0, 0, 0, 0);
    add(1, 0, 1, 47, 3,   1,  0, 0, 0, 0);
    add(1, 0, 0,  0, 0,   0, 47, 1, 0, 1);
    add(1, 1, 0,  0, 0,   0, 47, 1, 0, 1);
    add(1, 0, 0,  0, 0,   0, 47, 1, 0, 1);
    add(1, 1, 0,  0, 0,   0, 47, 1, 0, 1);
    add(1, 0, 0,  0, 0,   0, 47, 1, 0, 1);
    add(1, 1, 0,  0, 0,   0, 47, 1, 0, 1);
    add(1, 0, 0,  0, 0,   0, 47, 0, 0, 1);
    add(1, 1, 0,  0, 0,   0, 47, 0, 0, 1);
    add(1, 1, 0,  0, 0,   0, 47, 0, 0, 1);
    add(1, 1, 0,  0, 0,   0, 47, 0, 0, 1);
    add(1, 1, 1, 20, 0,   0, 47, 0, 0, 1);
    add(1, 0, 1, 20, 0,   1, 47, 0, 0, 0);
    add(1, 0, 0,  0, 0,   0, 20, 1, 0, 1);
    add(1, 1, 0,  0, 0,   0, 20, 1, 0, 1);
    add(1, 0, 0,  0, 0,   0, 20, 0, 0, 1);

    foreach (tbl[i]) begin
      cyc(tbl[i].rn, tbl[i].tk, tbl[i].v0, 0, tbl[i].h0, tbl[i].l0, 0, 0);
      chk($sformatf("vec%0d_req0_ready", i), r0, tbl[i].er0);
      chk($sformatf("vec%0d_req1_ready", i), r1, 0);
      chk($sformatf("vec%0d_hp", i), hp, tbl[i].ehp);
      chk($sformatf("vec%0d_active", i), act, tbl[i].eact);
      chk($sformatf("vec%0d_grant", i), gnt, tbl[i].egnt);
      chk($sformatf("vec%0d_busy", i), bsy, tbl[i].ebsy);
    end

    // Both valid in IDLE: requester 1 wins, requester 0 waits out note and gap.
    drain();
    cyc(1, 0, 1, 1, 47, 1, 100, 1);
    chk("both_r1", r1, 1);
    chk("both_r0", r0, 0);
    cyc(1, 1, 1, 0, 47, 1, 0, 0);
    chk("both_hp", hp, 100);
    chk("both_grant", gnt, 1);
    chk("both_active", act, 1);
    chk("both_r0_on", r0, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 1, 1, 0, 47, 1, 0, 0);
      chk($sformatf("both_gap%0d_r0", i), r0, 0);
      chk($sformatf("both_gap%0d_active", i), act, 0);
    end
    cyc(1, 0, 1, 0, 47, 1, 0, 0);
    chk("both_r0_after_gap", r0, 1);
    chk("both_idle_busy", bsy, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    chk("both_hp0", hp, 47);
    chk("both_grant0", gnt, 0);

    // Tick in the transfer cycle is ignored: len 2 lasts two further ticks.
    drain();
    cyc(1, 1, 1, 0, 33, 2, 0, 0);
    chk("xtick_r0", r0, 1);
    cyc(1, 1, 0, 0, 0, 0, 0, 0);
    chk("xtick_on0", act, 1);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    chk("xtick_on1", act, 1);
    cyc(1, 1, 0, 0, 0, 0, 0, 0);
    chk("xtick_on2", act, 1);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    chk("xtick_off", act, 0);
    chk("xtick_gap_busy", bsy, 1);

    // Reset mid-ON drops the note; pending req0 accepted right after release.
    drain();
    cyc(1, 0, 1, 0, 50, 5, 0, 0);
    chk("rst_xfer", r0, 1);
    cyc(1, 0, 1, 0, 50, 5, 0, 0);
    chk("rst_on_active", act, 1);
    chk("rst_on_r0", r0, 0);
    cyc(0, 0, 1, 0, 50, 5, 0, 0);
    chk("rst_ready_low", r0, 0);
    cyc(1, 0, 1, 0, 50, 5, 0, 0);
    chk("rst_active", act, 0);
    chk("rst_hp", hp, 0);
    chk("rst_busy", bsy, 0);
    chk("rst_release_r0", r0, 1);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_new_note", act, 1);

    // Requester 1 arrives at tick 2 of a len-5 requester-0 note.
    drain();
    cyc(1, 0, 1, 0, 47, 5, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 1, 0, 0, 100, 3);
`ifdef NOTE_ARB_PREEMPT_EN
    chk("pre_r1", r1, 1);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    chk("pre_hp", hp, 100);
    chk("pre_grant", gnt, 1);
    chk("pre_active", act, 1);
`else
    chk("pre_r1", r1, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    chk("pre_hp", hp, 47);
    chk("pre_grant", gnt, 0);
    chk("pre_active", act, 1);
`endif

    // Zero-gap instance: len 0 lasts one tick and returns straight to IDLE.
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 9, 0, 0, 0);
    chk("ng_r0", z_r0, 1);
    cyc(1, 1, 0, 0, 0, 0, 0, 0);
    chk("ng_active", z_act, 1);
    chk("ng_hp", z_hp, 9);
    cyc(1, 0, 1, 0, 9, 0, 0, 0);
    chk("ng_active_off", z_act, 0);
    chk("ng_idle", z_bsy, 0);
    chk("ng_next_r0", z_r0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/note_arbiter.md
# note_arbiter

Shares the single square-wave voice (`freq_synth`: half-period `hp` plus `active` gate) between two note requesters: the music sequencer (requester 0) and a sound-effect source (requester 1). Each note request is accepted with a valid/ready handshake and then gated on for a programmed number of ticks. A silent gap follows each note before the next grant. The block runs on the system clock and advances on a one-cycle `tick` enable from the audio prescaler; it owns all sequencing between note sources and the synth.

## Interface
- `HP_W`, default 7: width of the half-period value.
- `LEN_W`, default 5: width of the note length, in ticks.
- `GAP_TICKS`, default 4: ticks of silence after each note; 0 means no gap.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset: synchronous, active-low.
- `tick`  in  1  one-`clk` timing strobe.
- `req0_valid`, `req1_valid`  in  1  note request pending.
- `req0_hp`, `req1_hp`  in  HP_W  requested half-period.
- `req0_len`, `req1_len`  in  LEN_W  requested on-time, in ticks.
- `req0_ready`, `req1_ready`  out  1  request accepted this cycle.
- `hp`  out  HP_W  half-period to the synth.
- `active`  out  1  synth gate.
- `grant`  out  1  requester owning the current note.
- `busy`  out  1  high when the state is not IDLE.

## Operation
- State machine states: IDLE, ON, GAP.
- **Handshake:** a transfer occurs when `reqN_valid && reqN_ready` in the same cycle.
  - `reqN_ready` is combinational and at most one is high per cycle.
  - Both readies are 0 while `rst_n` = 0.
- **IDLE:**
  - Fixed priority: requester 1 wins if `req1_valid`; otherwise requester 0 if `req0_valid`.
  - The winner's `ready` = 1. On transfer:
    - latch `hp`;
    - set `grant` to the winner;
    - load `on_cnt` = len, where len 0 is treated as 1;
    - next state ON.
  - Requester 0 may starve while requester 1 stays valid. This is accepted.
- **ON:**
  - `active` = 1.
  - Each `tick` decrements `on_cnt`.
  - On a `tick` with `on_cnt` = 1:
    - if GAP_TICKS > 0, go to GAP with `gap_cnt` = GAP_TICKS;
    - otherwise go to IDLE.
- **GAP:**
  - `active` = 0; `hp` and `grant` hold.
  - Each `tick` decrements `gap_cnt`.
  - On a `tick` with `gap_cnt` = 1, go to IDLE.
- Readies are 0 in ON and GAP, unless the preemption feature (Configuration) applies.
- `tick` is ignored in IDLE and in the cycle of a transfer. The loaded count is not decremented that cycle.
- Counters are LEN_W bits and never underflow: decrement happens only when the count is ≥ 1.
- Reset in any state forces IDLE next cycle and clears all counters. An in-flight note is dropped silently.

## Timing
- Reset values: `hp` = 0, `active` = 0, `grant` = 0, `busy` = 0, `req0_ready` = `req1_ready` = 0.
- `hp`, `active`, `grant`, `busy` are registered.
- Transfer at cycle T gives `active` = 1 and the new `hp` at T+1.
- The `tick` that completes the note drops `active` in the following cycle.
- Audible on-time is `len` ticks. The first tick period is partial, measured from the transfer to the next `tick`.
- Gap is exactly GAP_TICKS `tick` strobes.
- Earliest next transfer is the cycle after the GAP→IDLE transition. Consequence: back-to-back notes have ≥ 1 `clk` of IDLE.
- When both requesters are valid in IDLE: only `req1_ready` = 1, and `req0_valid` must be held.

## Configuration
- `NOTE_ARB_PREEMPT_EN`, defined:
  - In ON or GAP with `grant` = 0, `req1_valid` raises `req1_ready` immediately.
  - The transfer reloads `hp` and `on_cnt`, sets `grant` = 1, and enters ON next cycle with `active` = 1, with no gap.
  - The interrupted requester-0 note is discarded, not resumed.
  - A requester-1 note is never preempted.
- `NOTE_ARB_PREEMPT_EN`, undefined: requests are accepted only in IDLE, as above.

## Test plan
- Reset, then `req0_valid`, `hp` = 47, `len` = 3, ticks every 8 clk, GAP_TICKS = 4:
  - `req0_ready` pulses one cycle;
  - next cycle `active` = 1 and `hp` = 47;
  - `active` falls after the 3rd tick;
  - `busy` clears after 4 more ticks.
- Both valid in IDLE (`hp` 47 vs 100):
  - `req1_ready` = 1, `req0_ready` = 0, `hp` = 100, `grant` = 1;
  - `req0` is accepted after `req1`'s note and gap complete.
- `len` = 0 → `active` lasts exactly one tick. With GAP_TICKS = 0, the state returns to IDLE on that tick.
- `tick` asserted in the same cycle as the transfer, `len` = 2 → `active` stays high through two further ticks, not one.
- Assert `rst_n` = 0 mid-ON for 1 cycle:
  - next cycle `active` = 0, `hp` = 0, `busy` = 0;
  - a pending `req0` is accepted in the first cycle after reset release.
- With `NOTE_ARB_PREEMPT_EN`: `req1` arrives at tick 2 of a `req0` `len` = 5 note:
  - `req1_ready` = 1 in that cycle;
  - next cycle `hp` = `req1_hp`, `grant` = 1, and `active` remains 1 with no low cycle.
